// File: rtl/hls_call_queue.sv
// Call/return front-end for an HLS kernel: buffers caller invocations in a FIFO,
// issues them to one kernel with a cap on outstanding calls, and returns done counts.
module hls_call_queue #(
    parameter int NUM_ARGS     = 5,
    parameter int ARG_W        = 64,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    input  logic [NUM_ARGS*ARG_W-1:0]           args,
    output logic                                done,
    input  logic                                stall,
    output logic                                k_start,
    input  logic                                k_busy,
    output logic [NUM_ARGS*ARG_W-1:0]           k_args,
    input  logic                                k_done,
    output logic                                k_stall,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [IW-1:0] MAX_L   = IW'(MAX_INFLIGHT);

    logic [NUM_ARGS*ARG_W-1:0] mem [DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [IW-1:0]             pend;
    logic                      accept;
    logic                      issue;
    logic                      kacc;
    logic                      ret;

    assign busy    = reset | (level == DEPTH_L);
    assign accept  = start & ~busy;
    assign k_start = (level != '0) & (inflight < MAX_L);
    assign issue   = k_start & ~k_busy;
    // pend == inflight means nothing is outstanding at the kernel
    assign k_stall = (pend == inflight);
    assign kacc    = k_done & ~k_stall;
    assign done    = (pend != '0);
    assign ret     = done & ~stall;
    assign k_args  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= args;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            inflight <= '0;
            pend     <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (accept && !issue) begin
                level <= level + LW'(1);
            end else if (!accept && issue) begin
                level <= level - LW'(1);
            end

            if (issue && !ret) begin
                inflight <= inflight + IW'(1);
            end else if (!issue && ret) begin
                inflight <= inflight - IW'(1);
            end

            if (kacc && !ret) begin
                pend <= pend + IW'(1);
            end else if (!kacc && ret) begin
                pend <= pend - IW'(1);
            end

            // a completion with nothing outstanding is dropped but remembered
            if (k_done && k_stall) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hls_call_queue.sv
// Self-checking bench for hls_call_queue: a per-cycle vector table plus
// directed sequences for fill, inflight cap, simultaneous events and mid-run reset.
module tb_hls_call_queue;

    logic         clock;
    logic         reset;
    logic         start;
    logic         busy;
    logic [319:0] args;
    logic         done;
    logic         stall;
    logic         k_start;
    logic         k_busy;
    logic [319:0] k_args;
    logic         k_done;
    logic         k_stall;
    logic [2:0]   level;
    logic [1:0]   inflight;
    logic         err;

    int checks = 0;
    int errors = 0;

    hls_call_queue dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .args     (args),
        .done     (done),
        .stall    (stall),
        .k_start  (k_start),
        .k_busy   (k_busy),
        .k_args   (k_args),
        .k_done   (k_done),
        .k_stall  (k_stall),
        .level    (level),
        .inflight (inflight),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       st, kb, kd, sl;
        logic [2:0] lv;
        logic [1:0] inf;
        logic       dn, ks, by, er, kst;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(input int st, kb, kd, sl, lv, inf, dn, ks, by, er, kst);
        vec_t v;
        v.st = st[0]; v.kb = kb[0]; v.kd = kd[0]; v.sl = sl[0];
        v.lv = lv[2:0]; v.inf = inf[1:0];
        v.dn = dn[0]; v.ks = ks[0]; v.by = by[0]; v.er = er[0]; v.kst = kst[0];
        return v;
    endfunction

    // arg i = {id, (i+1)*0x1000}; id 0 gives A=0x1000 .. r=0x5000
    function automatic logic [319:0] mk(input int id);
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*64 +: 64] = {32'(id), 32'((i + 1) * 32'h1000)};
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) begin
            checks++;
            if (int'(dut.pend) > int'(inflight) || int'(inflight) > 2 || int'(level) > 4) begin
                errors++;
                $display("FAIL invariant pend=%0d inflight=%0d level=%0d", dut.pend, inflight, level);
            end
        end
    endtask

    task automatic idle();
        start  = 1'b0;
        stall  = 1'b0;
        k_busy = 1'b0;
        k_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    int issues;
    int popped;

    initial begin
        args = '0;
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_kstart", int'(k_start), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_err", int'(err), 0);

        // single call round trip
        args = mk(0); start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_kstart", int'(k_start), 1);
        chka("t1_kargs", k_args, mk(0));
        chk("t1_level", int'(level), 1);
        tick();
        chk("t1_inflight", int'(inflight), 1);
        chk("t1_level0", int'(level), 0);
        chk("t1_kstart0", int'(k_start), 0);
        k_done = 1'b1;
        tick();
        k_done = 1'b0;
        chk("t1_done", int'(done), 1);
        tick();
        chk("t1_done0", int'(done), 0);
        chk("t1_inflight0", int'(inflight), 0);
        chk("t1_level_end", int'(level), 0);

        // vector table: st kb kd sl | level inflight done k_start busy err k_stall after edge
        tbl[0]  = mkv(1,1,0,0, 1,0,0,1,0,0,1);
        tbl[1]  = mkv(1,1,0,0, 2,0,0,1,0,0,1);
        tbl[2]  = mkv(1,1,0,0, 3,0,0,1,0,0,1);
        tbl[3]  = mkv(1,1,0,0, 4,0,0,1,1,0,1);
        tbl[4]  = mkv(1,1,0,0, 4,0,0,1,1,0,1);
        tbl[5]  = mkv(0,0,0,0, 3,1,0,1,0,0,0);
        tbl[6]  = mkv(0,0,0,0, 2,2,0,0,0,0,0);
        tbl[7]  = mkv(0,0,1,0, 2,2,1,0,0,0,0);
        tbl[8]  = mkv(0,0,0,0, 2,1,0,1,0,0,0);
        tbl[9]  = mkv(0,0,0,0, 1,2,0,0,0,0,0);
        tbl[10] = mkv(0,0,1,1, 1,2,1,0,0,0,0);
        tbl[11] = mkv(0,0,1,1, 1,2,1,0,0,0,1);
        tbl[12] = mkv(0,0,1,1, 1,2,1,0,0,1,1);
        tbl[13] = mkv(0,0,0,0, 1,1,1,1,0,1,1);
        tbl[14] = mkv(0,0,0,0, 0,1,0,0,0,1,0);
        tbl[15] = mkv(0,0,1,0, 0,1,1,0,0,1,1);
        tbl[16] = mkv(0,0,0,0, 0,0,0,0,0,1,1);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].st; k_busy = tbl[i].kb; k_done = tbl[i].kd; stall = tbl[i].sl;
            args = mk(100 + i);
            tick();
            chk($sformatf("row%0d_level", i), int'(level), int'(tbl[i].lv));
            chk($sformatf("row%0d_inflight", i), int'(inflight), int'(tbl[i].inf));
            chk($sformatf("row%0d_done", i), int'(done), int'(tbl[i].dn));
            chk($sformatf("row%0d_kstart", i), int'(k_start), int'(tbl[i].ks));
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].by));
            chk($sformatf("row%0d_err", i), int'(err), int'(tbl[i].er));
            chk($sformatf("row%0d_kstall", i), int'(k_stall), int'(tbl[i].kst));
        end

        // fill to DEPTH, reject a 5th, then drain in order
        do_reset();
        k_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            start = 1'b1; args = mk(i);
            tick();
        end
        chk("t2_level_full", int'(level), 4);
        chk("t2_busy", int'(busy), 1);
        args = mk(5);
        tick();
        chk("t2_no_accept", int'(level), 4);
        start = 1'b0; k_busy = 1'b0;
        popped = 0;
        for (int c = 0; c < 40; c++) begin
            if (popped == 4 && inflight == 2'd0 && !done) break;
            k_done = ~k_stall;
            if (k_start) begin
                popped++;
                chka($sformatf("t2_pop%0d", popped), k_args, mk(popped));
            end
            tick();
        end
        k_done = 1'b0;
        chk("t2_pops", popped, 4);
        chk("t2_level_end", int'(level), 0);
        chk("t2_inflight_end", int'(inflight), 0);

        // inflight cap
        do_reset();
        k_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            start = 1'b1; args = mk(i);
            tick();
        end
        start = 1'b0; k_busy = 1'b0;
        issues = 0;
        repeat (6) begin
            if (k_start) issues++;
            tick();
        end
        chk("t3_issues", issues, 2);
        chk("t3_kstart", int'(k_start), 0);
        chk("t3_level", int'(level), 2);
        chk("t3_inflight", int'(inflight), 2);
        k_busy = 1'b1; k_done = 1'b1;
        tick();
        k_done = 1'b0;
        tick();
        chk("t3_inflight_ret", int'(inflight), 1);
        chk("t3_kstart_again", int'(k_start), 1);
        chka("t3_kargs3", k_args, mk(3));

        // simultaneous events; all four cannot coincide at MAX_INFLIGHT=2
        // (kacc needs pend<inflight, ret needs pend>0, issue needs inflight<2)
        do_reset();
        k_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            start = 1'b1; args = mk(i);
            tick();
        end
        start = 1'b0; k_busy = 1'b0;
        tick();
        k_busy = 1'b1; k_done = 1'b1;
        tick();
        k_done = 1'b0;
        chk("t5_pre_level", int'(level), 2);
        chk("t5_pre_inflight", int'(inflight), 1);
        chk("t5_pre_done", int'(done), 1);
        start = 1'b1; args = mk(4); k_busy = 1'b0; stall = 1'b0;
        tick();
        start = 1'b0;
        chk("t5_acc_iss_ret_level", int'(level), 2);
        chk("t5_acc_iss_ret_inflight", int'(inflight), 1);
        chk("t5_acc_iss_ret_done", int'(done), 0);
        tick();
        k_busy = 1'b1; k_done = 1'b1;
        tick();
        chk("t5_pre2_inflight", int'(inflight), 2);
        chk("t5_pre2_done", int'(done), 1);
        tick();
        k_done = 1'b0;
        chk("t5_kacc_ret_done", int'(done), 1);
        chk("t5_kacc_ret_inflight", int'(inflight), 1);
        chk("t5_err", int'(err), 0);

        // reset mid-run, with err set beforehand
        do_reset();
        k_done = 1'b1;
        tick();
        k_done = 1'b0;
        chk("t6_err_set", int'(err), 1);
        k_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            start = 1'b1; args = mk(i);
            tick();
        end
        start = 1'b0; k_busy = 1'b0;
        tick();
        tick();
        k_busy = 1'b1; start = 1'b1; args = mk(5);
        tick();
        start = 1'b0; k_done = 1'b1;
        tick();
        k_done = 1'b0;
        chk("t6_pre_level", int'(level), 3);
        chk("t6_pre_inflight", int'(inflight), 2);
        chk("t6_pre_done", int'(done), 1);
        reset = 1'b1; start = 1'b1; k_busy = 1'b0;
        #1;
        chk("t6_busy_in_reset", int'(busy), 1);
        tick();
        chk("t6_level", int'(level), 0);
        chk("t6_inflight", int'(inflight), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_err", int'(err), 0);
        chk("t6_kstart", int'(k_start), 0);
        reset = 1'b0; start = 1'b0;
        #1;
        chk("t6_busy_after", int'(busy), 0);
        tick();
        chk("t6_kstart_after", int'(k_start), 0);
        chk("t6_done_after", int'(done), 0);
        chk("t6_level_after", int'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
